shape_cmd_gen: RTL and testbench
================================

// Module: shape_cmd_gen
// PURPOSE
//  Parametrised draw-mode controller: cycles draw modes, captures cursor points, emits shape
//  commands (rect/circle/line/polyline segment) through a command FIFO with valid/ready to the
//  shape rasteriser. Adds cancel, multi-point polyline, backpressure and overflow reporting.
//  Sits between button debouncers / cursor position regs and the rasteriser.
// PARAMETERS
//  COORD_W    8  width of each x/y coordinate
//  NUM_MODES  5  mode count: 0=free,1=rect,2=circle,3=line,4=polyline (must be 2..8)
//  MAX_PTS    8  max points in one polyline chain (>=2); chain auto-ends on reaching it
//  FIFO_DEPTH 4  command FIFO entries, power of two >=2
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          async active-low reset
//  btn_mode   in   1          level, debounced; rising edge = next mode
//  btn_point  in   1          level; rising edge = capture point
//  btn_cancel in   1          level; rising edge = drop held anchor / end chain
//  x_pos      in   COORD_W    cursor x
//  y_pos      in   COORD_W    cursor y
//  mode       out  3          current mode
//  anchor_set out  1          an anchor point is held
//  pt_count   out  4          points captured in current chain (0..MAX_PTS)
//  cmd_valid  out  1          FIFO head valid
//  cmd_ready  in   1          rasteriser accepts head
//  cmd_mode   out  3          mode of head cmd (1..4)
//  cmd_x0/y0  out  COORD_W    point A (circle: centre)
//  cmd_x1/y1  out  COORD_W    point B (circle: radius point)
//  overflow   out  1          sticky: command dropped because FIFO full; cleared only by reset
// BEHAVIOUR
//  - Reset: mode=0, anchor_set=0, pt_count=0, FIFO empty (cmd_valid=0, cmd_* =0), overflow=0,
//    edge-detect prev regs=0 (button held through reset gives an edge on first cycle after).
//  - Edge detect: ev_x = btn_x & ~btn_x_q, evaluated each clk; btn_x_q <= btn_x.
//  - Priority in one cycle: cancel > mode > point. Lower-priority events that cycle are dropped.
//  - Mode event: mode <= (mode==NUM_MODES-1) ? 0 : mode+1; anchor_set<=0, pt_count<=0.
//    FIFO contents untouched.
//  - Cancel event: anchor_set<=0, pt_count<=0; mode unchanged; FIFO untouched.
//  - Point event, mode 0: ignored.
//  - States: IDLE (anchor_set=0), ANCHORED (anchor_set=1).
//    IDLE + point: anchor<=(x,y), anchor_set<=1, pt_count<=1; no command.
//    ANCHORED + point, modes 1-3: push {mode,anchor,(x,y)}; ->IDLE, pt_count<=0.
//    ANCHORED + point, mode 4: push {4,anchor,(x,y)}; anchor<=(x,y), pt_count+1;
//      if new pt_count==MAX_PTS ->IDLE, pt_count<=0.
//  - Push blocked when FIFO full and no pop same cycle: command dropped, overflow<=1, but
//    point/state updates still occur as if pushed (UI never stalls).
//  - Push+pop same cycle when full is legal (no overflow).
//  - FIFO: registered, first-word fall-through; pushed cmd visible on cmd_* with cmd_valid=1
//    on the cycle after the point edge (1-cycle latency) when FIFO was empty. Pop when
//    cmd_valid & cmd_ready. cmd_* hold stable while cmd_valid & ~cmd_ready.
//  - Pointers wrap mod FIFO_DEPTH; occupancy counter COUNT_W=$clog2(FIFO_DEPTH)+1 bits.
//  - Coordinates passed unchanged; no ordering/normalisation of A/B (rasteriser's job).
//  - Async reset mid-chain or mid-handshake: everything returns to reset values immediately.
// STRUCTURE
//  - Package draw_pkg: MODE_FREE/RECT/CIRC/LINE/POLY localparams, MODE_W=3, cmd field
//    offsets and CMD_W = MODE_W+4*COORD_W packing helpers; shared with rasteriser.
//  - Sub-module shape_cmd_fifo (#(WIDTH=CMD_W, DEPTH=FIFO_DEPTH)): FWFT FIFO with
//    push/full/pop/valid; controller FSM + edge detect in the top.
// TESTING
//  1 Mode cycling: 5 btn_mode pulses -> mode 1,2,3,4,0; anchor_set cleared each time.
//  2 Rect: line mode 1, point at (10,20) then (50,60), cmd_ready=1 -> one cmd
//    {1,10,20,50,60}, cmd_valid 1 cycle after 2nd edge, single beat.
//  3 Polyline MAX_PTS=8: 8 point edges at (i,i) -> 7 cmds {4,(i-1,i-1),(i,i)}; after 8th
//    anchor_set=0, pt_count=0; 9th edge only sets anchor.
//  4 Backpressure: cmd_ready=0, 5 line commands, FIFO_DEPTH=4 -> 4 held, overflow=1,
//    then cmd_ready=1 drains first 4 in order, 5th absent.
//  5 Simultaneous: cancel+point same cycle while ANCHORED -> no cmd, anchor_set=0;
//    mode+point -> mode advances, no anchor captured.
//  6 Reset mid-chain with 2 cmds queued and anchor held -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/draw_pkg.sv
// Draw-mode encodings and shape command field layout, shared with the rasteriser.
package draw_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_FREE = 3'd0;
    localparam logic [MODE_W-1:0] MODE_RECT = 3'd1;
    localparam logic [MODE_W-1:0] MODE_CIRC = 3'd2;
    localparam logic [MODE_W-1:0] MODE_LINE = 3'd3;
    localparam logic [MODE_W-1:0] MODE_POLY = 3'd4;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ANCHORED = 1'b1
    } draw_state_t;

    // Command word, MSB first: {mode, x0, y0, x1, y1}.
    function automatic int cmd_w(input int coord_w);
        return MODE_W + 4 * coord_w;
    endfunction

    function automatic int off_y1(input int coord_w);
        return 0 * coord_w;
    endfunction

    function automatic int off_x1(input int coord_w);
        return 1 * coord_w;
    endfunction

    function automatic int off_y0(input int coord_w);
        return 2 * coord_w;
    endfunction

    function automatic int off_x0(input int coord_w);
        return 3 * coord_w;
    endfunction

    function automatic int off_mode(input int coord_w);
        return 4 * coord_w;
    endfunction

endpackage

// File: rtl/shape_cmd_fifo.sv
// First-word fall-through command FIFO; a push shows on the head one cycle later.
// Push while full is accepted only if a pop happens in the same cycle; head is zero when empty.
module shape_cmd_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    input  logic             pop,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);
    localparam int AW      = $clog2(DEPTH);
    localparam int COUNT_W = AW + 1;
    localparam logic [AW-1:0]      PTR_ONE  = AW'(1);
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_FULL = COUNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == CNT_FULL);
    assign vld       = (r_count != '0);
    assign w_pop_ok  = pop & vld;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign dat       = vld ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/shape_cmd_gen.sv
// Draw-mode controller: button edges + cursor -> shape commands, queued for the rasteriser.
// Command appears one cycle after the closing point edge; a full queue drops it and sets overflow.
module shape_cmd_gen
    import draw_pkg::*;
#(
    parameter int COORD_W    = 8,
    parameter int NUM_MODES  = 5,
    parameter int MAX_PTS    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_mode,
    input  logic               btn_point,
    input  logic               btn_cancel,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    output logic [2:0]         mode,
    output logic               anchor_set,
    output logic [3:0]         pt_count,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [2:0]         cmd_mode,
    output logic [COORD_W-1:0] cmd_x0,
    output logic [COORD_W-1:0] cmd_y0,
    output logic [COORD_W-1:0] cmd_x1,
    output logic [COORD_W-1:0] cmd_y1,
    output logic               overflow
);
    localparam int CMD_W = cmd_w(COORD_W);
    localparam logic [2:0] MODE_LAST = 3'(NUM_MODES - 1);
    localparam logic [3:0] PT_MAX    = 4'(MAX_PTS);

    logic               r_btn_mode_q, r_btn_point_q, r_btn_cancel_q;
    logic               w_ev_mode, w_ev_point, w_ev_cancel;
    draw_state_t        r_state, w_state_nxt;
    logic [2:0]         r_mode, w_mode_nxt;
    logic [3:0]         r_pt_count, w_pt_nxt;
    logic [COORD_W-1:0] r_anchor_x, r_anchor_y;
    logic               w_anchor_ld;
    logic               w_push, w_full, w_pop;
    logic [CMD_W-1:0]   w_push_dat, w_head;
    logic               r_overflow;

    assign w_ev_mode   = btn_mode   & ~r_btn_mode_q;
    assign w_ev_point  = btn_point  & ~r_btn_point_q;
    assign w_ev_cancel = btn_cancel & ~r_btn_cancel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_mode_q   <= 1'b0;
            r_btn_point_q  <= 1'b0;
            r_btn_cancel_q <= 1'b0;
        end else begin
            r_btn_mode_q   <= btn_mode;
            r_btn_point_q  <= btn_point;
            r_btn_cancel_q <= btn_cancel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_FREE;
            r_pt_count <= '0;
            r_anchor_x <= '0;
            r_anchor_y <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_pt_count <= w_pt_nxt;
            if (w_anchor_ld) begin
                r_anchor_x <= x_pos;
                r_anchor_y <= y_pos;
            end
        end
    end

    // Cancel beats mode beats point; a losing event in the same cycle is simply lost.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_pt_nxt    = r_pt_count;
        w_anchor_ld = 1'b0;
        if (w_ev_cancel) begin
            w_state_nxt = ST_IDLE;
            w_pt_nxt    = '0;
        end else if (w_ev_mode) begin
            w_mode_nxt  = (r_mode == MODE_LAST) ? MODE_FREE : r_mode + 3'd1;
            w_state_nxt = ST_IDLE;
            w_pt_nxt    = '0;
        end else if (w_ev_point && r_mode != MODE_FREE) begin
            if (r_state == ST_IDLE) begin
                w_state_nxt = ST_ANCHORED;
                w_pt_nxt    = 4'd1;
                w_anchor_ld = 1'b1;
            end else if (r_mode != MODE_POLY) begin
                w_state_nxt = ST_IDLE;
                w_pt_nxt    = '0;
            end else begin
                w_anchor_ld = 1'b1;
                if (r_pt_count + 4'd1 == PT_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_pt_nxt    = '0;
                end else begin
                    w_pt_nxt = r_pt_count + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_push     = w_ev_point & ~w_ev_cancel & ~w_ev_mode &
                     (r_mode != MODE_FREE) & (r_state == ST_ANCHORED);
        w_push_dat = {r_mode, r_anchor_x, r_anchor_y, x_pos, y_pos};
    end

    assign w_pop = cmd_valid & cmd_ready;

    // The UI never stalls: a refused push is dropped and only flagged here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end

    shape_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_push),
        .push_dat (w_push_dat),
        .full     (w_full),
        .pop      (w_pop),
        .vld      (cmd_valid),
        .dat      (w_head)
    );

    assign mode       = r_mode;
    assign anchor_set = (r_state == ST_ANCHORED);
    assign pt_count   = r_pt_count;
    assign overflow   = r_overflow;
    assign cmd_mode   = w_head[off_mode(COORD_W) +: MODE_W];
    assign cmd_x0     = w_head[off_x0(COORD_W) +: COORD_W];
    assign cmd_y0     = w_head[off_y0(COORD_W) +: COORD_W];
    assign cmd_x1     = w_head[off_x1(COORD_W) +: COORD_W];
    assign cmd_y1     = w_head[off_y1(COORD_W) +: COORD_W];

endmodule

// File: tb/tb_shape_cmd_gen.sv
// Directed bench for shape_cmd_gen; expected commands go into a queue checked by a monitor.
module tb_shape_cmd_gen;

    typedef struct packed {
        logic [2:0] m;
        logic [7:0] x0;
        logic [7:0] y0;
        logic [7:0] x1;
        logic [7:0] y1;
    } cmd_t;

    logic       clk, rst_n;
    logic       btn_mode, btn_point, btn_cancel;
    logic [7:0] x_pos, y_pos;
    logic [2:0] mode;
    logic       anchor_set;
    logic [3:0] pt_count;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_mode;
    logic [7:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic       overflow;

    cmd_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    shape_cmd_gen #(
        .COORD_W    (8),
        .NUM_MODES  (5),
        .MAX_PTS    (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_point  (btn_point),
        .btn_cancel (btn_cancel),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .mode       (mode),
        .anchor_set (anchor_set),
        .pt_count   (pt_count),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_x1     (cmd_x1),
        .cmd_y1     (cmd_y1),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive a one-cycle button pulse, then settle to the following negedge.
    task automatic press(input logic c, input logic m, input logic p,
                         input logic [7:0] x, input logic [7:0] y);
        @(posedge clk); #1;
        x_pos = x; y_pos = y;
        btn_cancel = c; btn_mode = m; btn_point = p;
        @(posedge clk); #1;
        btn_cancel = 1'b0; btn_mode = 1'b0; btn_point = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_cmd(input logic [2:0] m, input logic [7:0] x0, input logic [7:0] y0,
                              input logic [7:0] x1, input logic [7:0] y1);
        cmd_t c;
        c.m = m; c.x0 = x0; c.y0 = y0; c.x1 = x1; c.y1 = y1;
        exp_q.push_back(c);
    endtask

    // Monitor: every accepted beat must match the oldest expected command.
    initial begin
        cmd_t got, want;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_valid && cmd_ready) begin
                got = {cmd_mode, cmd_x0, cmd_y0, cmd_x1, cmd_y1};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL cmd_unexpected: got %h, expected no command", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL cmd_beat: got %h, expected %h", got, want);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int wait_cyc;
        rst_n = 1'b0; cmd_ready = 1'b1;
        btn_mode = 1'b0; btn_point = 1'b0; btn_cancel = 1'b0;
        x_pos = '0; y_pos = '0;
        repeat (3) @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_anchor", anchor_set, 0);
        check("rst_pt_count", pt_count, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode cycling, with an anchor dropped by a mode change.
        press(0, 1, 0, 0, 0);   check("mode_1", mode, 1);
        press(0, 0, 1, 3, 3);   check("anchor_taken", anchor_set, 1);
        press(0, 1, 0, 0, 0);   check("mode_2", mode, 2);
        check("mode_clears_anchor", anchor_set, 0);
        press(0, 1, 0, 0, 0);   check("mode_3", mode, 3);
        press(0, 1, 0, 0, 0);   check("mode_4", mode, 4);
        press(0, 1, 0, 0, 0);   check("mode_wrap_0", mode, 0);
        press(0, 0, 1, 4, 4);   check("free_ignores_point", anchor_set, 0);
        press(0, 1, 0, 0, 0);

        // Rect with latency and single-beat check.
        press(0, 0, 1, 10, 20);
        check("rect_anchor", anchor_set, 1);
        check("rect_pt1", pt_count, 1);
        expect_cmd(3'd1, 10, 20, 50, 60);
        @(posedge clk); #1;
        x_pos = 50; y_pos = 60; btn_point = 1'b1;
        @(negedge clk);
        check("rect_not_yet_valid", cmd_valid, 0);
        @(posedge clk); #1;
        btn_point = 1'b0;
        @(negedge clk);
        check("rect_valid_next", cmd_valid, 1);
        @(negedge clk);
        check("rect_single_beat", cmd_valid, 0);
        check("rect_idle", anchor_set, 0);

        // Simultaneous events.
        press(0, 0, 1, 5, 5);
        press(1, 0, 1, 7, 7);
        check("cancel_wins_anchor", anchor_set, 0);
        check("cancel_wins_pt", pt_count, 0);
        check("cancel_keeps_mode", mode, 1);
        press(0, 1, 1, 8, 8);
        check("mode_wins_mode", mode, 2);
        check("mode_wins_anchor", anchor_set, 0);
        press(0, 1, 0, 0, 0);
        check("to_line", mode, 3);

        // Backpressure: four lines queue, the fifth is dropped.
        @(posedge clk); #1; cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] b;
            b = 8'(k * 20 + 5);
            if (k < 4) expect_cmd(3'd3, b, b + 8'd1, b + 8'd2, b + 8'd3);
            press(0, 0, 1, b, b + 8'd1);
            press(0, 0, 1, b + 8'd2, b + 8'd3);
            if (k == 3) check("no_overflow_at_4", overflow, 0);
        end
        check("overflow_set", overflow, 1);
        check("held_valid", cmd_valid, 1);
        check("held_x0", cmd_x0, 5);
        @(negedge clk);
        check("held_x0_stable", cmd_x0, 5);
        check("held_y1_stable", cmd_y1, 8);
        @(posedge clk); #1; cmd_ready = 1'b1;
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 40) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("fifth_absent", cmd_valid, 0);

        // Polyline auto-ends at MAX_PTS.
        press(0, 1, 0, 0, 0);
        check("to_poly", mode, 4);
        for (int i = 1; i <= 8; i++) begin
            if (i >= 2) expect_cmd(3'd4, 8'(i - 1), 8'(i - 1), 8'(i), 8'(i));
            press(0, 0, 1, 8'(i), 8'(i));
            if (i == 3) check("poly_pt3", pt_count, 3);
            if (i == 7) check("poly_anchor_7", anchor_set, 1);
        end
        check("poly_end_anchor", anchor_set, 0);
        check("poly_end_pt", pt_count, 0);
        repeat (3) @(negedge clk);
        check("poly_all_seen", exp_q.size(), 0);
        press(0, 0, 1, 9, 9);
        check("poly9_anchor", anchor_set, 1);
        check("poly9_pt", pt_count, 1);
        press(1, 0, 0, 0, 0);
        check("poly_cancel", anchor_set, 0);

        // Async reset mid-chain with queued commands.
        @(posedge clk); #1; cmd_ready = 1'b0;
        press(0, 0, 1, 1, 1);
        press(0, 0, 1, 2, 2);
        press(0, 0, 1, 3, 3);
        check("pre_rst_valid", cmd_valid, 1);
        check("pre_rst_pt", pt_count, 3);
        #2; rst_n = 1'b0;
        #1;
        check("arst_mode", mode, 0);
        check("arst_anchor", anchor_set, 0);
        check("arst_pt", pt_count, 0);
        check("arst_valid", cmd_valid, 0);
        check("arst_cmd_x0", cmd_x0, 0);
        check("arst_cmd_mode", cmd_mode, 0);
        check("arst_overflow", overflow, 0);
        @(negedge clk); #1; rst_n = 1'b1;
        cmd_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_empty", cmd_valid, 0);
        check("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
